lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage between the execute stage and the byte-lane data memory.
- Accepts one memory request at a time and drives the data memory's addr/r_enable/w_enable/w_size/w_data interface.
- For loads, waits for the memory's ready pulse, then sign- or zero-extends the returned data and presents it to writeback under a valid/ready handshake.
- Detects illegal access types and read timeouts.

Parameters:
- ADDR_W, 32, width of request and memory address.
- TIMEOUT, 15, maximum cycles spent in WAIT before a load is abandoned with an error (range 1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  access type, RISC-V encoding.
- req_addr  in  ADDR_W  byte address; any alignment.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register tag for loads.
- mem_addr  out  ADDR_W  address to data memory.
- mem_r_enable  out  1  read strobe.
- mem_w_enable  out  1  write strobe.
- mem_w_size  out  2  00 byte, 01 half, 10 word.
- mem_w_data  out  32  store data to memory, unshifted.
- mem_r_data  in  32  read data; byte at mem_addr is in [7:0].
- mem_ready  in  1  one-cycle read-complete pulse.
- resp_valid  out  1  load result valid.
- resp_ready  in  1  writeback accepts result.
- resp_data  out  32  extended load data.
- resp_rd  out  5  tag of the completed load.
- resp_err  out  1  illegal funct3 or timeout.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: state goes to IDLE immediately. All outputs are 0 except req_ready = 1. Timeout counter and captured registers are cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- Handshake: req_ready = (state == IDLE). A request is accepted on the edge where req_valid & req_ready. On acceptance, req_store, req_funct3, req_addr, req_wdata and req_rd are captured.
- Legal encodings:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
- Illegal accepted request: IDLE -> RESP with resp_err = 1, resp_data = 0. No memory strobe is issued. The same applies to an illegal store.
- IDLE -> ISSUE on a legal accept.
- ISSUE (exactly 1 cycle):
  - mem_addr = captured addr.
  - Load: mem_r_enable = 1. Store: mem_w_enable = 1, mem_w_size = funct3[1:0], mem_w_data = captured wdata.
  - Store -> IDLE. Load -> WAIT; the timeout counter is cleared.
- WAIT:
  - mem_addr is held at the captured address, because memory read data steering depends on addr[1:0]. Both strobes are 0.
  - If mem_ready = 1: capture the extended mem_r_data and go to RESP with err = 0.
  - Otherwise the counter increments. When it reaches TIMEOUT, go to RESP with err = 1 and data = 0.
- Extension:
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: pass [31:0] unchanged.
- RESP:
  - resp_valid = 1; resp_data, resp_rd and resp_err are held stable until resp_ready = 1.
  - On the edge where resp_valid & resp_ready, go to IDLE. resp_valid drops the next cycle.
  - No bypass: a new request cannot be accepted in the same cycle as the response handshake.
- Stores produce no response; a store's completion is the ISSUE cycle.
- Latency, load, memory ready one cycle after r_enable:
  - Accept at edge 0, mem_r_enable high in cycle 1, mem_ready in cycle 2, resp_valid from cycle 3.
  - With resp_ready held high, req_ready returns in cycle 4.
- Throughput, store: accept, ISSUE, then req_ready high again, i.e. one store every 2 cycles.
- Misaligned addresses are legal and passed through unmodified; the memory handles lane rotation.
- Strobe rule: mem_r_enable and mem_w_enable are never both 1. Each is 1 only in ISSUE.
- Spurious ready: mem_ready outside WAIT is ignored.
- Reset mid-operation: a pending load is dropped and no response is produced. A store whose ISSUE cycle is cut by reset has its strobe deasserted immediately.

Test Plan:
- Aligned word: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with resp_ready = 1 -> w_enable for 1 cycle with w_size 10; resp_valid 3 cycles after load accept, resp_data 0xDEADBEEF, resp_err 0.
- Extension: memory returns 0x000080F0. LB -> 0xFFFFFFF0; LBU -> 0x000000F0; LH -> 0xFFFF80F0; LHU -> 0x000080F0.
- Misaligned: LH at 0x13 -> mem_addr stays 0x13 for ISSUE and WAIT; resp_data equals the sign-extended mem_r_data[15:0].
- Backpressure: resp_ready = 0 for 5 cycles after resp_valid -> resp_valid, data and rd stable; req_ready = 0 throughout; a new request is accepted only after the handshake.
- Error paths: load funct3 011 -> resp_err 1, data 0, no strobe. Load with mem_ready never asserted -> resp_err 1 exactly TIMEOUT (15) cycles after entering WAIT.
- Reset mid-WAIT: reset asserted asynchronously -> strobes 0 and resp_valid 0 immediately, req_ready 1; no response is produced afterwards.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store control stage: issues one data-memory access at a time, extends load
// data and hands it to writeback under a valid/ready handshake.
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [1:0]        mem_w_size,
    output logic [31:0]       mem_w_data,
    input  logic [31:0]       mem_r_data,
    input  logic              mem_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              r_state;
    state_t              w_next;
    logic                r_store;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [4:0]          r_rd;
    logic [7:0]          r_cnt;
    logic [31:0]         r_resp_data;
    logic                r_resp_err;
    logic                w_accept;
    logic                w_legal;
    logic [7:0]          w_cnt_inc;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'b0, d[7:0]};
            3'b101:  extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_legal = 1'b0;
        if (req_store) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Illegal requests skip the memory entirely and go straight to an error response.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_legal ? S_ISSUE : S_RESP;
            S_ISSUE: w_next = r_store ? S_IDLE : S_WAIT;
            S_WAIT:  if (mem_ready || (w_cnt_inc == TIMEOUT_CNT)) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (r_state == S_IDLE);
        mem_addr     = '0;
        mem_r_enable = 1'b0;
        mem_w_enable = 1'b0;
        mem_w_size   = 2'b00;
        mem_w_data   = 32'b0;
        resp_valid   = 1'b0;
        resp_data    = 32'b0;
        resp_rd      = 5'b0;
        resp_err     = 1'b0;
        case (r_state)
            S_ISSUE: begin
                mem_addr = r_addr;
                if (r_store) begin
                    mem_w_enable = 1'b1;
                    mem_w_size   = r_funct3[1:0];
                    mem_w_data   = r_wdata;
                end else begin
                    mem_r_enable = 1'b1;
                end
            end
            // Address held through WAIT since the memory steers read lanes from addr[1:0].
            S_WAIT: mem_addr = r_addr;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_resp_data;
                resp_rd    = r_rd;
                resp_err   = r_resp_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store     <= 1'b0;
            r_funct3    <= 3'b0;
            r_addr      <= '0;
            r_wdata     <= 32'b0;
            r_rd        <= 5'b0;
            r_cnt       <= 8'b0;
            r_resp_data <= 32'b0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_store     <= req_store;
                    r_funct3    <= req_funct3;
                    r_addr      <= req_addr;
                    r_wdata     <= req_wdata;
                    r_rd        <= req_rd;
                    r_resp_data <= 32'b0;
                    r_resp_err  <= !w_legal;
                end
                S_ISSUE: r_cnt <= 8'b0;
                S_WAIT: begin
                    if (mem_ready) begin
                        r_resp_data <= extend(r_funct3, mem_r_data);
                        r_resp_err  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TIMEOUT_CNT) begin
                            r_resp_data <= 32'b0;
                            r_resp_err  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads with every extension, backpressure,
// illegal encodings, read timeout and asynchronous reset in flight.
module tb_lsu_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [1:0]  mem_w_size;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic        mem_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int compared;
    int mismatched;

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_addr(mem_addr), .mem_r_enable(mem_r_enable), .mem_w_enable(mem_w_enable),
        .mem_w_size(mem_w_size), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
        .mem_ready(mem_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd);
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        req_valid  = 1'b1;
    endtask

    // Load with memory ready one cycle after the read strobe and writeback always ready.
    task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] expData);
        applyStimulus(1'b0, f3, addr, 32'h0, rd);
        resp_ready = 1'b1;
        cyc();
        req_valid = 1'b0;
        checkOutput({tag, "_issue_ren"}, 32'(mem_r_enable), 32'd1);
        checkOutput({tag, "_issue_wen"}, 32'(mem_w_enable), 32'd0);
        checkOutput({tag, "_issue_addr"}, mem_addr, addr);
        mem_ready  = 1'b1;
        mem_r_data = rdata;
        cyc();
        checkOutput({tag, "_wait_addr"}, mem_addr, addr);
        checkOutput({tag, "_wait_ren"}, 32'(mem_r_enable), 32'd0);
        checkOutput({tag, "_wait_valid"}, 32'(resp_valid), 32'd0);
        cyc();
        mem_ready  = 1'b0;
        mem_r_data = 32'h0;
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "_resp_data"}, resp_data, expData);
        checkOutput({tag, "_resp_rd"}, 32'(resp_rd), 32'(rd));
        checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        cyc();
        checkOutput({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'h0;
        mem_r_data = 32'h0;
        mem_ready  = 1'b0;
        resp_ready = 1'b0;
        cyc();
        cyc();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_ren", 32'(mem_r_enable), 32'd0);
        checkOutput("rst_wen", 32'(mem_w_enable), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        $display("[TB] aligned word store then load");
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        cyc();
        req_valid = 1'b0;
        checkOutput("sw_wen", 32'(mem_w_enable), 32'd1);
        checkOutput("sw_ren", 32'(mem_r_enable), 32'd0);
        checkOutput("sw_size", 32'(mem_w_size), 32'd2);
        checkOutput("sw_data", mem_w_data, 32'hDEADBEEF);
        checkOutput("sw_addr", mem_addr, 32'h10);
        checkOutput("sw_busy", 32'(req_ready), 32'd0);
        cyc();
        checkOutput("sw_wen_off", 32'(mem_w_enable), 32'd0);
        checkOutput("sw_ready_again", 32'(req_ready), 32'd1);
        runLoad("lw", 3'b010, 32'h10, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        $display("[TB] load extension");
        runLoad("lb", 3'b000, 32'h20, 5'd1, 32'h000080F0, 32'hFFFFFFF0);
        runLoad("lbu", 3'b100, 32'h20, 5'd2, 32'h000080F0, 32'h000000F0);
        runLoad("lh", 3'b001, 32'h20, 5'd3, 32'h000080F0, 32'hFFFF80F0);
        runLoad("lhu", 3'b101, 32'h20, 5'd4, 32'h000080F0, 32'h000080F0);
        runLoad("lb_pos", 3'b000, 32'h21, 5'd6, 32'hFFFFFF7F, 32'h0000007F);

        $display("[TB] misaligned halfword");
        runLoad("lh_mis", 3'b001, 32'h13, 5'd8, 32'h12349ABC, 32'hFFFF9ABC);

        $display("[TB] response backpressure");
        applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, 5'd9);
        resp_ready = 1'b0;
        cyc();
        req_valid  = 1'b0;
        mem_ready  = 1'b1;
        mem_r_data = 32'h11223344;
        cyc();
        cyc();
        mem_ready  = 1'b0;
        mem_r_data = 32'h0;
        applyStimulus(1'b1, 3'b000, 32'h30, 32'hCAFEF00D, 5'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_data", resp_data, 32'h11223344);
            checkOutput("bp_rd", 32'(resp_rd), 32'd9);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        resp_ready = 1'b1;
        checkOutput("bp_hs_req_ready", 32'(req_ready), 32'd0);
        cyc();
        checkOutput("bp_after_valid", 32'(resp_valid), 32'd0);
        checkOutput("bp_after_req_ready", 32'(req_ready), 32'd1);
        checkOutput("bp_no_early_wen", 32'(mem_w_enable), 32'd0);
        cyc();
        req_valid = 1'b0;
        checkOutput("sb_wen", 32'(mem_w_enable), 32'd1);
        checkOutput("sb_size", 32'(mem_w_size), 32'd0);
        checkOutput("sb_data", mem_w_data, 32'hCAFEF00D);
        checkOutput("sb_addr", mem_addr, 32'h30);
        cyc();

        $display("[TB] illegal encodings");
        applyStimulus(1'b0, 3'b011, 32'h40, 32'h0, 5'd7);
        resp_ready = 1'b1;
        cyc();
        req_valid = 1'b0;
        checkOutput("ill_ld_ren", 32'(mem_r_enable), 32'd0);
        checkOutput("ill_ld_wen", 32'(mem_w_enable), 32'd0);
        checkOutput("ill_ld_valid", 32'(resp_valid), 32'd1);
        checkOutput("ill_ld_err", 32'(resp_err), 32'd1);
        checkOutput("ill_ld_data", resp_data, 32'h0);
        checkOutput("ill_ld_rd", 32'(resp_rd), 32'd7);
        cyc();
        checkOutput("ill_ld_done", 32'(resp_valid), 32'd0);
        applyStimulus(1'b1, 3'b100, 32'h44, 32'h55AA55AA, 5'd11);
        cyc();
        req_valid = 1'b0;
        checkOutput("ill_st_wen", 32'(mem_w_enable), 32'd0);
        checkOutput("ill_st_valid", 32'(resp_valid), 32'd1);
        checkOutput("ill_st_err", 32'(resp_err), 32'd1);
        cyc();

        $display("[TB] read timeout");
        applyStimulus(1'b0, 3'b010, 32'h50, 32'h0, 5'd3);
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int i = 1; i < 15; i++) begin
            cyc();
            checkOutput("to_still_waiting", 32'(resp_valid), 32'd0);
        end
        cyc();
        checkOutput("to_valid", 32'(resp_valid), 32'd1);
        checkOutput("to_err", 32'(resp_err), 32'd1);
        checkOutput("to_data", resp_data, 32'h0);
        checkOutput("to_rd", 32'(resp_rd), 32'd3);
        cyc();

        $display("[TB] asynchronous reset in flight");
        applyStimulus(1'b0, 3'b010, 32'h60, 32'h0, 5'd2);
        cyc();
        req_valid = 1'b0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rw_ren", 32'(mem_r_enable), 32'd0);
        checkOutput("rw_valid", 32'(resp_valid), 32'd0);
        checkOutput("rw_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rw_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_r_data = 32'h99999999;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checkOutput("rw_no_resp", 32'(resp_valid), 32'd0);
        end
        mem_ready = 1'b0;
        applyStimulus(1'b1, 3'b001, 32'h70, 32'h0000BEEF, 5'd0);
        cyc();
        req_valid = 1'b0;
        checkOutput("rs_wen_on", 32'(mem_w_enable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rs_wen_cut", 32'(mem_w_enable), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
